// File: rtl/cdc_event_arbiter_pkg.sv
// Shared types for the CDC event arbiter.
// Only the FSM state encoding lives here.
package cdc_event_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a bus of independent level signals.
// The reset is active-low and asynchronous; each bit is synchronized on its own.
module cdc_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cdc_event_arbiter.sv
// Turns rising edges on asynchronous request lines into a round-robin served
// valid/ready event stream. Define CDC_EVENT_ARBITER_OVERFLOW_EN for sticky overflow flags.
module cdc_event_arbiter
   import cdc_event_arbiter_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] async_req,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ID_W-1:0]  evt_id,
   output logic [N_REQ-1:0] pending
`ifdef CDC_EVENT_ARBITER_OVERFLOW_EN
   ,
   output logic [N_REQ-1:0] overflow,
   input  logic             overflow_clr
`endif
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   state_t           state;
   state_t           state_next;
   logic [N_REQ-1:0] q;
   logic [N_REQ-1:0] q_prev;
   logic [N_REQ-1:0] edges;
   logic [N_REQ-1:0] clear_mask;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  winner;
   logic             handshake;

   cdc_sync2 #(.WIDTH(N_REQ)) u_sync (
      .clk   (clk),
      .rst_n (~rst),
      .d     (async_req),
      .q     (q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_prev <= '0;
      else     q_prev <= q;
   end

   assign edges      = q & ~q_prev;
   assign handshake  = evt_valid && evt_ready;
   assign clear_mask = handshake ? (N_REQ'(1) << evt_id) : '0;

   // A fresh edge on the source being retired keeps it pending (set wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clear_mask) | edges;
   end

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      logic [ID_W:0] idx;
      winner = '0;
      idx    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (idx >= (ID_W + 1)'(N_REQ)) idx = idx - (ID_W + 1)'(N_REQ);
         if (pending[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pending != '0) state_next = OFFER;
         OFFER:   if (evt_ready)     state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   always_comb begin
      evt_valid = (state == OFFER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_id <= '0;
         rr_ptr <= '0;
      end else if (state == IDLE && pending != '0) begin
         evt_id <= winner;
      end else if (handshake) begin
         rr_ptr <= (evt_id == LAST_ID) ? '0 : evt_id + ID_W'(1);
      end
   end

`ifdef CDC_EVENT_ARBITER_OVERFLOW_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) overflow <= '0;
      else     overflow <= (overflow_clr ? '0 : overflow) | (edges & pending & ~clear_mask);
   end
`endif

endmodule

// File: doc/cdc_event_arbiter.md
CDC_EVENT_ARBITER -- requirements
Module: cdc_event_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of asynchronous event sources, legal range 2..16.
REQ-002 SHALL have localparam ID_W = $clog2(N_REQ): width of the event id.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-high.
REQ-005 SHALL have port async_req, input, N_REQ: asynchronous level inputs; a rising edge on bit i is one event for source i.
REQ-006 SHALL have port evt_valid, output, 1: an event is offered.
REQ-007 SHALL have port evt_ready, input, 1: consumer accepts; handshake occurs when evt_valid && evt_ready at posedge.
REQ-008 SHALL have port evt_id, output, ID_W: source index of the offered event.
REQ-009 SHALL have port pending, output, N_REQ: registered per-source pending flags.

Function
REQ-010 SHALL pass async_req through a two-flop synchronizer; the synchronized value is q.
REQ-011 SHALL detect rising edges as q & ~q_prev, where q_prev is q registered one cycle.
REQ-012 SHALL set pending[i] on the cycle after edge i is detected.
REQ-013 SHALL, for an input that rises before posedge 1 and stays stable, report q=1 after posedge 2, pending=1 after posedge 3, and evt_valid=1 after posedge 4.
REQ-014 SHALL implement FSM states IDLE and OFFER; the reset state is IDLE.
REQ-015 SHALL, in IDLE with pending != 0, latch a round-robin winner into evt_id and enter OFFER.
REQ-016 SHALL select the winner as the first set pending bit at or after rr_ptr, wrapping from N_REQ-1 to 0.
REQ-017 SHALL assert evt_valid only in OFFER and hold evt_id stable until the handshake.
REQ-018 SHALL, on handshake, clear pending[evt_id], set rr_ptr = evt_id+1 (wrapping to 0 at N_REQ), and return to IDLE.
REQ-019 SHALL give a one-cycle bubble after each handshake, so the maximum rate is one event per 2 cycles.
REQ-020 SHALL, when a new edge for source evt_id coincides with that source's handshake, let set win: pending[evt_id] stays 1.
REQ-021 SHALL merge an edge on an already-pending source into the existing event; without the macro in REQ-025, no indication is given.
REQ-022 SHALL keep simultaneous edges on several sources all pending and serve them in round-robin order.

Reset
REQ-023 SHALL clear all state while rst is high: synchronizer flops, q_prev, pending, rr_ptr, evt_id. The FSM is in IDLE and evt_valid=0.
REQ-024 SHALL, because q_prev resets to 0, generate one event for an input held high across reset release, 4 edges after release. A reset mid-OFFER drops the offered event and all pending events.

Configuration
REQ-025 SHALL, with CDC_EVENT_ARBITER_OVERFLOW_EN defined, add output port overflow (N_REQ) and input port overflow_clr (1).
- overflow[i] is sticky: set when an edge arrives while pending[i] is already 1 (excluding the set-wins case in REQ-020).
- overflow is cleared by overflow_clr or rst; set wins over clear.
REQ-026 SHALL, without the macro, have neither port nor logic present; merging per REQ-021 is silent.

Structure
REQ-027 SHALL place the state enum typedef (IDLE, OFFER) in package cdc_event_arbiter_pkg.
REQ-028 SHALL reuse sub-module cdc_sync2 with WIDTH=N_REQ as the synchronizer, with its rst_n driven by ~rst.
REQ-029 SHALL keep round-robin selection combinational inside cdc_event_arbiter; no further sub-modules.

Verification
REQ-030 SHALL cover single event: N_REQ=4, evt_ready=1, async_req 0000->0100 -> evt_valid after the 4th posedge with evt_id=2; pending=0000 after the handshake.
REQ-031 SHALL cover simultaneous events: async_req 0000->1011 with rr_ptr=0 -> ids served 0, 1, 3, each offer 2 cycles apart.
REQ-032 SHALL cover backpressure: evt_ready=0 for 5 cycles during OFFER -> evt_valid and evt_id stay constant; then evt_ready=1 -> one handshake.
REQ-033 SHALL cover merge/overflow: source 1 rises, falls, and rises again while pending -> exactly one event; with the macro, overflow=0010 until overflow_clr pulses.
REQ-034 SHALL cover set-wins: a source-0 edge arrives on the same cycle as its handshake -> pending[0] stays 1 and a second id=0 event follows.
REQ-035 SHALL cover reset: rst pulsed during OFFER -> evt_valid=0 and pending=0 immediately; input held high at release -> one event after 4 posedges.
